// File: rtl/ddfs_phase_core_if.sv
// Tuning/sample bus of the DDFS phase core.
// The optional square_out signal is present only when DDFS_SQUARE_OUT_EN is defined.
interface ddfs_phase_core_if #(
  parameter int unsigned DAC_WIDTH = 8
);
  logic [6:0]           fw;
  logic [2:0]           freq_control;
  logic                 enable;
  logic [DAC_WIDTH-1:0] dac_out;
  logic                 sample_valid;
  logic                 phase_wrap;
  logic                 update_ack;
`ifdef DDFS_SQUARE_OUT_EN
  logic                 square_out;

  modport master (
    output fw, freq_control, enable,
    input  dac_out, sample_valid, phase_wrap, update_ack, square_out
  );
  modport slave (
    input  fw, freq_control, enable,
    output dac_out, sample_valid, phase_wrap, update_ack, square_out
  );
`else
  modport master (
    output fw, freq_control, enable,
    input  dac_out, sample_valid, phase_wrap, update_ack
  );
  modport slave (
    input  fw, freq_control, enable,
    output dac_out, sample_valid, phase_wrap, update_ack
  );
`endif
endinterface

// File: rtl/ddfs_phase_core.sv
// DDFS phase core: prescaled phase accumulator feeding a quarter-wave sine ROM.
// Tuning changes are taken over only at phase wrap to keep the output phase-continuous.
// Optional feature macro: DDFS_SQUARE_OUT_EN adds square_out (acc MSB aligned with dac_out).
module ddfs_phase_core #(
  parameter int unsigned ACC_WIDTH      = 24,
  parameter int unsigned LUT_ADDR_WIDTH = 8,
  parameter int unsigned DAC_WIDTH      = 8
) (
  input logic              clk,
  input logic              rst_n,
  ddfs_phase_core_if.slave bus
);

  localparam int unsigned MAG_W = DAC_WIDTH - 1;
  localparam int unsigned DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  // Quarter-wave magnitude table, sampled at the centre of each address bin.
  logic [MAG_W-1:0] w_rom [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam real ANG = 1.5707963267948966 * (real'(gi) + 0.5) / real'(DEPTH);
    localparam real AMP = real'((1 << MAG_W) - 1);
    localparam int  MAG = $rtoi(AMP * $sin(ANG) + 0.5);
    assign w_rom[gi] = MAG[MAG_W-1:0];
  end

  logic [6:0]           r_fw_sh, r_fw_act;
  logic [2:0]           r_fc_sh, r_fc_act;
  logic [6:0]           r_presc;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_wrap, r_ack;

  logic [6:0]           w_limit;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_tick, w_carry, w_load, w_fc_chg, w_chg;
  logic [1:0]           w_q;
  logic [LUT_ADDR_WIDTH-1:0] w_addr;

  // Tick/wrap/load decisions for the current cycle.
  always_comb begin
    w_limit  = 7'((8'd1 << r_fc_act) - 8'd1);
    w_tick   = bus.enable && (r_presc == w_limit);
    w_sum    = {1'b0, r_acc} + {{(ACC_WIDTH-6){1'b0}}, r_fw_act};
    w_carry  = w_tick && w_sum[ACC_WIDTH];
    w_load   = !bus.enable || (r_fw_act == '0) || w_carry;
    w_fc_chg = w_load && (r_fc_sh != r_fc_act);
    w_chg    = w_load && ((r_fw_sh != r_fw_act) || (r_fc_sh != r_fc_act));
    w_q      = r_acc[ACC_WIDTH-1 -: 2];
    w_addr   = r_acc[ACC_WIDTH-3 -: LUT_ADDR_WIDTH];
    if (w_q[0]) w_addr = ~w_addr;
  end

  // Shadow/active tuning registers, prescaler and phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fw_sh  <= '0;
      r_fc_sh  <= '0;
      r_fw_act <= '0;
      r_fc_act <= '0;
      r_presc  <= '0;
      r_acc    <= '0;
      r_wrap   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_fw_sh <= bus.fw;
      r_fc_sh <= bus.freq_control;
      if (w_load) begin
        r_fw_act <= r_fw_sh;
        r_fc_act <= r_fc_sh;
      end
      if (!bus.enable || w_fc_chg || w_tick) r_presc <= '0;
      else                                   r_presc <= r_presc + 7'd1;
      if (!bus.enable)  r_acc <= '0;
      else if (w_tick)  r_acc <= w_sum[ACC_WIDTH-1:0];
      r_wrap <= w_carry;
      r_ack  <= w_chg;
    end
  end

  logic                      r_v1, r_v2, r_v3, r_en1, r_en2;
  logic [1:0]                r_q1, r_q2;
  logic [LUT_ADDR_WIDTH-1:0] r_a1;
  logic [MAG_W-1:0]          r_mag;
  logic [DAC_WIDTH-1:0]      r_dac;

  // Phase-to-amplitude pipeline; a disabled core feeds phase 0 so dac_out drains to midscale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_en1 <= 1'b0;
      r_en2 <= 1'b0;
      r_q1  <= '0;
      r_q2  <= '0;
      r_a1  <= '0;
      r_mag <= '0;
      r_dac <= MID;
    end else begin
      r_v1  <= w_tick;
      r_en1 <= bus.enable;
      r_q1  <= bus.enable ? w_q : 2'b00;
      r_a1  <= bus.enable ? w_addr : '0;
      r_v2  <= r_v1;
      r_en2 <= r_en1;
      r_q2  <= r_q1;
      r_mag <= w_rom[r_a1];
      r_v3  <= r_v2;
      if (r_v2 || !r_en2) begin
        if (r_q2[1]) r_dac <= MID - {1'b0, r_mag};
        else         r_dac <= MID + {1'b0, r_mag};
      end
    end
  end

`ifdef DDFS_SQUARE_OUT_EN
  logic r_sq;

  // Square output taken from the S2 quadrant bit so it lines up with dac_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sq <= 1'b0;
    else        r_sq <= r_q2[1];
  end

  assign bus.square_out = r_sq;
`endif

  assign bus.dac_out      = r_dac;
  assign bus.sample_valid = r_v3;
  assign bus.phase_wrap   = r_wrap;
  assign bus.update_ack   = r_ack;

endmodule

// File: tb/tb_ddfs_phase_core.sv
// Scoreboard bench for ddfs_phase_core (ACC_WIDTH=10, LUT_ADDR_WIDTH=8, DAC_WIDTH=8).
`timescale 1ns/1ps
module tb_ddfs_phase_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddfs_phase_core_if #(.DAC_WIDTH(8)) bus ();

  ddfs_phase_core #(
    .ACC_WIDTH      (10),
    .LUT_ADDR_WIDTH (8),
    .DAC_WIDTH      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dac;
    logic       msb;
  } samp_t;

  samp_t sq[$];
  int    wq[$];
  int    aq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int dmin = 255, dmax = 0;
  int sv_prev = 0, sv_last = 0, wr_prev = 0, wr_last = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected sample for phase p straight from the sine definition.
  function automatic logic [7:0] exp_dac(input int p);
    real s;
    int  mag;
    s   = $sin(2.0 * 3.141592653589793 * (real'(p) + 0.5) / 1024.0);
    mag = $rtoi(127.0 * ((s < 0.0) ? -s : s) + 0.5);
    return (s >= 0.0) ? 8'(128 + mag) : 8'(128 - mag);
  endfunction

  // Reference model: shadow/active tuning, prescaler and accumulator.
  logic [6:0] m_fw_sh = '0, m_fw_act = '0;
  logic [2:0] m_fc_sh = '0, m_fc_act = '0;
  int m_cnt = 0, m_acc = 0, m_sum, m_lim;
  bit m_tick, m_carry, m_load;
  samp_t m_s;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_fw_sh = '0; m_fw_act = '0; m_fc_sh = '0; m_fc_act = '0;
      m_cnt = 0; m_acc = 0;
      sq.delete(); wq.delete(); aq.delete();
    end else begin
      cyc++;
      m_lim   = (1 << m_fc_act) - 1;
      m_tick  = bus.enable && (m_cnt == m_lim);
      m_sum   = m_acc + int'(m_fw_act);
      m_carry = m_tick && (m_sum >= 1024);
      m_load  = !bus.enable || (m_fw_act == 0) || m_carry;
      if (m_tick) begin
        m_s.cyc = cyc + 2;
        m_s.dac = exp_dac(m_acc);
        m_s.msb = (m_acc >= 512);
        sq.push_back(m_s);
      end
      if (m_carry) wq.push_back(cyc);
      if (m_load && ((m_fw_sh != m_fw_act) || (m_fc_sh != m_fc_act))) aq.push_back(cyc);
      if (!bus.enable || (m_load && (m_fc_sh != m_fc_act)) || m_tick) m_cnt = 0;
      else m_cnt++;
      if (!bus.enable) m_acc = 0;
      else if (m_tick) m_acc = m_sum % 1024;
      if (m_load) begin
        m_fw_act = m_fw_sh;
        m_fc_act = m_fc_sh;
      end
      m_fw_sh = bus.fw;
      m_fc_sh = bus.freq_control;
    end
  end

  // Monitor: pop and compare whenever the DUT presents a sample, wrap or ack.
  samp_t s;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        check("sample_missing", 0, sq[0].cyc);
        sq.delete(0);
      end
      while (wq.size() > 0 && wq[0] < cyc) begin
        check("wrap_missing", 0, wq[0]);
        wq.delete(0);
      end
      while (aq.size() > 0 && aq[0] < cyc) begin
        check("ack_missing", 0, aq[0]);
        aq.delete(0);
      end
      if (bus.sample_valid) begin
        if (sq.size() == 0) check("sample_unexpected", 1, 0);
        else begin
          s = sq.pop_front();
          check("sample_cycle", cyc, s.cyc);
          check("sample_dac", int'(bus.dac_out), int'(s.dac));
`ifdef DDFS_SQUARE_OUT_EN
          check("square_out", int'(bus.square_out), int'(s.msb));
`endif
          if (int'(bus.dac_out) < dmin) dmin = int'(bus.dac_out);
          if (int'(bus.dac_out) > dmax) dmax = int'(bus.dac_out);
          sv_prev = sv_last;
          sv_last = cyc;
        end
      end
      if (bus.phase_wrap) begin
        if (wq.size() == 0) check("wrap_unexpected", 1, 0);
        else check("wrap_cycle", cyc, wq.pop_front());
        wr_prev = wr_last;
        wr_last = cyc;
      end
      if (bus.update_ack) begin
        if (aq.size() == 0) check("ack_unexpected", 1, 0);
        else check("ack_cycle", cyc, aq.pop_front());
      end
    end
  end

  // Directed stimulus.
  initial begin
    bus.fw = '0; bus.freq_control = '0; bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dac",   int'(bus.dac_out), 128);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_wrap",  int'(bus.phase_wrap), 0);
    check("rst_ack",   int'(bus.update_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fw=1, fc=0: one sample per clock, wrap every 1024 clocks
    bus.fw = 7'd1; bus.freq_control = 3'd0; bus.enable = 1'b1;
    dmin = 255; dmax = 0;
    repeat (2100) @(negedge clk);
    check("peak_dac", dmax, 255);
    check("min_dac", dmin, 1);
    check("wrap_period_fw1", wr_last - wr_prev, 1024);

    // fw=4, fc=3: sample every 8 clocks, wrap every 2048
    bus.fw = 7'd4; bus.freq_control = 3'd3;
    repeat (5400) @(negedge clk);
    check("sample_period_fc3", sv_last - sv_prev, 8);
    check("wrap_period_fw4", wr_last - wr_prev, 2048);

    // retune to fw=8 mid-period; takes effect at the next wrap
    repeat (700) @(negedge clk);
    bus.fw = 7'd8;
    repeat (4300) @(negedge clk);
    check("wrap_period_fw8", wr_last - wr_prev, 1024);
    check("sample_period_fw8", sv_last - sv_prev, 8);

    // disable mid-period, then restart from phase 0
    repeat (300) @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_dac", int'(bus.dac_out), 128);
    check("dis_valid", int'(bus.sample_valid), 0);
    repeat (8) @(negedge clk);
    check("dis_hold_dac", int'(bus.dac_out), 128);
    bus.enable = 1'b1;
    repeat (300) @(negedge clk);

    // asynchronous reset in the middle of a sample period
    #2 rst_n = 1'b0;
    #1;
    check("arst_dac",   int'(bus.dac_out), 128);
    check("arst_valid", int'(bus.sample_valid), 0);
    check("arst_wrap",  int'(bus.phase_wrap), 0);
    check("arst_ack",   int'(bus.update_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);

    bus.enable = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_empty", sq.size() + wq.size() + aq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
